// File: rtl/idex_pkg.sv
// Shared definitions for the ID->EX stage: control-bundle width, bit layout and field helpers.
package idex_pkg;

   localparam int unsigned CtrlW      = 12;

   localparam int unsigned CtrlLoad   = 0;
   localparam int unsigned CtrlStore  = 1;
   localparam int unsigned CtrlBranch = 2;
   localparam int unsigned CtrlJal    = 3;
   localparam int unsigned CtrlJalr   = 4;
   localparam int unsigned CtrlOpaPc  = 5;
   localparam int unsigned CtrlOpbImm = 6;
   localparam int unsigned CtrlUseRs1 = 7;
   localparam int unsigned CtrlUseRs2 = 8;

   localparam int unsigned CtrlAluLsb = 9;
   localparam int unsigned CtrlAluW   = 2;
   localparam int unsigned CtrlResLsb = 11;
   localparam int unsigned CtrlResW   = 1;

   typedef logic [CtrlW-1:0] ctrl_t;

   function automatic logic [CtrlAluW-1:0] ctrl_alu(ctrl_t c);
      return c[CtrlAluLsb +: CtrlAluW];
   endfunction

   function automatic logic [CtrlResW-1:0] ctrl_result_src(ctrl_t c);
      return c[CtrlResLsb +: CtrlResW];
   endfunction

endpackage

// File: rtl/idex_pipe_stage_if.sv
// ID->EX stage bus: decode-side request, writeback snoop, flush and EX-side response.
// master = decode/EX environment, slave = the pipeline stage.
interface idex_pipe_stage_if
   import idex_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned RA_W   = 5,
   parameter int unsigned CTRL_W = CtrlW
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [XLEN-1:0]   in_pc;
   logic [XLEN-1:0]   in_pc4;
   logic [XLEN-1:0]   in_rs1_data;
   logic [XLEN-1:0]   in_rs2_data;
   logic [XLEN-1:0]   in_imm;
   logic [CTRL_W-1:0] in_ctrl;

   logic              wb_we;
   logic [RA_W-1:0]   wb_rd;
   logic [XLEN-1:0]   wb_data;

   logic              flush;

   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_op_a;
   logic [XLEN-1:0]   out_op_b;
   logic [XLEN-1:0]   out_store;
   logic [RA_W-1:0]   out_rs1;
   logic [RA_W-1:0]   out_rs2;
   logic [RA_W-1:0]   out_rd;
   logic [XLEN-1:0]   out_pc;
   logic [XLEN-1:0]   out_pc4;
   logic [31:0]       out_instr;
   logic [CTRL_W-1:0] out_ctrl;
   logic              load_use_stall;

   modport master (
      output in_valid, in_instr, in_pc, in_pc4, in_rs1_data, in_rs2_data, in_imm, in_ctrl,
      output wb_we, wb_rd, wb_data, flush, out_ready,
      input  in_ready, out_valid, out_op_a, out_op_b, out_store, out_rs1, out_rs2, out_rd,
      input  out_pc, out_pc4, out_instr, out_ctrl, load_use_stall
   );

   modport slave (
      input  in_valid, in_instr, in_pc, in_pc4, in_rs1_data, in_rs2_data, in_imm, in_ctrl,
      input  wb_we, wb_rd, wb_data, flush, out_ready,
      output in_ready, out_valid, out_op_a, out_op_b, out_store, out_rs1, out_rs2, out_rd,
      output out_pc, out_pc4, out_instr, out_ctrl, load_use_stall
   );

endinterface

// File: rtl/idex_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: a main (output) entry plus one skid entry.
// in_ready is a flop output so the upstream path is never combinational through this block.
module idex_skid_buf #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         main_valid_q, main_valid_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         in_fire, out_fire;

   assign in_ready  = ~skid_valid_q;
   assign out_valid = main_valid_q;
   assign out_data  = main_q;

   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_d       = main_q;
      skid_d       = skid_q;
      in_fire      = in_valid & ~skid_valid_q;
      out_fire     = main_valid_q & out_ready;

      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         // Skid full means in_ready is low; only the drain side can move.
         if (out_fire) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
         end
      end else if (main_valid_q && !out_fire) begin
         if (in_fire) begin
            skid_d       = in_data;
            skid_valid_d = 1'b1;
         end
      end else begin
         main_valid_d = in_fire;
         if (in_fire) begin
            main_d = in_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_q       <= '0;
         skid_q       <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_q       <= main_d;
         skid_q       <= skid_d;
      end
   end

endmodule

// File: rtl/idex_pipe_stage.sv
// ID->EX pipeline stage: operand select, load-use interlock and skid-buffered capture.
// Optional writeback bypass at capture when IDEX_WB_BYPASS_EN is defined.
module idex_pipe_stage
   import idex_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned RA_W   = 5,
   parameter int unsigned CTRL_W = CtrlW
) (
   input logic              clk,
   input logic              rst,
   idex_pipe_stage_if.slave bus
);

   localparam int unsigned PW = 32 + 5 * XLEN + 3 * RA_W + CTRL_W;

   logic [RA_W-1:0] rs1, rs2, rd;
   logic [XLEN-1:0] rs1_val, rs2_val, op_a, op_b;
   logic            use_rs1, use_rs2, lu_hit;
   logic            lu_pend_q;
   logic [RA_W-1:0] lu_rd_q;
   logic            buf_in_valid, buf_out_valid, out_fire, out_is_load;
   logic [PW-1:0]   buf_in_data, buf_out_data;

   assign rs1 = bus.in_instr[15 +: RA_W];
   assign rs2 = bus.in_instr[20 +: RA_W];
   assign rd  = bus.in_instr[7 +: RA_W];

`ifdef IDEX_WB_BYPASS_EN
   assign rs1_val = (bus.wb_we && (bus.wb_rd != '0) && (bus.wb_rd == rs1)) ?
                    bus.wb_data : bus.in_rs1_data;
   assign rs2_val = (bus.wb_we && (bus.wb_rd != '0) && (bus.wb_rd == rs2)) ?
                    bus.wb_data : bus.in_rs2_data;
`else
   logic unused_wb;
   assign unused_wb = ^{bus.wb_we, bus.wb_rd, bus.wb_data};
   assign rs1_val   = bus.in_rs1_data;
   assign rs2_val   = bus.in_rs2_data;
`endif

   assign op_a    = bus.in_ctrl[CtrlOpaPc] ? bus.in_pc : rs1_val;
   assign op_b    = bus.in_ctrl[CtrlOpbImm] ? bus.in_imm : rs2_val;
   assign use_rs1 = bus.in_ctrl[CtrlUseRs1];
   assign use_rs2 = bus.in_ctrl[CtrlUseRs2];

   // lu_rd_q can never be x0 while lu_pend_q is set, but keep the x0 guard explicit.
   assign lu_hit = lu_pend_q &
                   ((use_rs1 & (rs1 != '0) & (rs1 == lu_rd_q)) |
                    (use_rs2 & (rs2 != '0) & (rs2 == lu_rd_q)));

   assign bus.load_use_stall = lu_hit & bus.in_valid;
   assign buf_in_valid       = bus.in_valid & ~lu_hit & ~bus.flush;
   assign buf_in_data        = {bus.in_instr, bus.in_pc, bus.in_pc4, op_a, op_b, rs2_val,
                                rs1, rs2, rd, bus.in_ctrl};

   idex_skid_buf #(
      .W (PW)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (bus.flush),
      .in_valid  (buf_in_valid),
      .in_ready  (bus.in_ready),
      .in_data   (buf_in_data),
      .out_valid (buf_out_valid),
      .out_ready (bus.out_ready),
      .out_data  (buf_out_data)
   );

   assign {bus.out_instr, bus.out_pc, bus.out_pc4, bus.out_op_a, bus.out_op_b, bus.out_store,
           bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_ctrl} = buf_out_data;
   assign bus.out_valid = buf_out_valid;

   assign out_fire    = buf_out_valid & bus.out_ready;
   assign out_is_load = out_fire & bus.out_ctrl[CtrlLoad] & (bus.out_rd != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         lu_pend_q <= 1'b0;
         lu_rd_q   <= '0;
      end else begin
         lu_pend_q <= out_is_load & ~bus.flush;
         if (out_is_load) begin
            lu_rd_q <= bus.out_rd;
         end
      end
   end

endmodule

// File: tb/tb_idex_pipe_stage.sv
// Scoreboard bench for idex_pipe_stage: directed vectors push expectations, a negedge
// monitor pops and compares every EX-side transfer.
module tb_idex_pipe_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   idex_pipe_stage_if bus ();

   idex_pipe_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef IDEX_WB_BYPASS_EN
   localparam bit BypassOn = 1'b1;
`else
   localparam bit BypassOn = 1'b0;
`endif

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] op_a;
      logic [31:0] op_b;
      logic [31:0] store;
      logic [11:0] ctrl;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
   } exp_t;

   exp_t exp_q[$];
   int   out_cycles[$];
   int   cyc       = 0;
   int   n_checks  = 0;
   int   n_fail    = 0;
   int   stall_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic checki(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: every EX-side transfer must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.out_valid && bus.out_ready) begin
         checki("out_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_data", {bus.out_instr, bus.out_op_a, bus.out_op_b, bus.out_store},
                  {e.instr, e.op_a, e.op_b, e.store});
            check("out_meta", {bus.out_pc, bus.out_pc4, 20'(bus.out_ctrl), 8'(bus.out_rd),
                               8'(bus.out_rs1), 8'(bus.out_rs2)},
                  {e.pc, e.pc + 32'd4, 20'(e.ctrl), 8'(e.rd), 8'(e.rs1), 8'(e.rs2)});
         end
         out_cycles.push_back(cyc);
      end
      if (!rst && bus.load_use_stall) stall_cnt++;
   end

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs1d, input logic [31:0] rs2d,
                        input logic [31:0] imm, input logic [11:0] ctrl);
      bus.in_valid    = 1'b1;
      bus.in_instr    = instr;
      bus.in_pc       = pc;
      bus.in_pc4      = pc + 32'd4;
      bus.in_rs1_data = rs1d;
      bus.in_rs2_data = rs2d;
      bus.in_imm      = imm;
      bus.in_ctrl     = ctrl;
   endtask

   // Called just after a rising edge; returns just after the edge on which the entry fired.
   task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1d, input logic [31:0] rs2d,
                       input logic [31:0] imm, input logic [11:0] ctrl,
                       input logic [31:0] e_a, input logic [31:0] e_b,
                       input logic [31:0] e_st, output int waits);
      exp_t e;
      bit   ok;
      drive(instr, pc, rs1d, rs2d, imm, ctrl);
      waits = 0;
      ok    = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.in_ready && !bus.load_use_stall) begin
            ok = 1'b1;
            break;
         end
         waits++;
         @(posedge clk); #1;
      end
      checki("send_accepted", ok, 1);
      if (ok) begin
         e.instr = instr;  e.pc = pc;  e.op_a = e_a;  e.op_b = e_b;  e.store = e_st;
         e.ctrl  = ctrl;   e.rd = instr[11:7];  e.rs1 = instr[19:15];  e.rs2 = instr[24:20];
         exp_q.push_back(e);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int k = 0; k < 40; k++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
      end
      checki({name, "_drained"}, exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic lu_case(input string pfx, input logic [31:0] ld, input logic [31:0] add,
                          input int exp_lat, input int exp_stall);
      int w;
      int t0;
      send(ld, 32'h200, 32'h40, 32'h0, 32'd8, 12'h0C1, 32'h40, 32'd8, 32'h0, w);
      @(posedge clk); #1;
      out_cycles.delete();
      stall_cnt = 0;
      t0        = cyc;
      send(add, 32'h204, 32'h11, 32'h22, 32'h0, 12'h180, 32'h11, 32'h22, 32'h22, w);
      wait_drain(pfx);
      checki({pfx, "_stalls"}, stall_cnt, exp_stall);
      checki({pfx, "_count"}, out_cycles.size(), 1);
      if (out_cycles.size() == 1) checki({pfx, "_latency"}, out_cycles[0] - t0, exp_lat);
   endtask

   initial begin
      int          w;
      int          wsum;
      logic [31:0] ins;
      logic [31:0] wb_exp_a;

      bus.in_valid = 1'b0;  bus.in_instr = '0;  bus.in_pc = '0;  bus.in_pc4 = '0;
      bus.in_rs1_data = '0; bus.in_rs2_data = '0; bus.in_imm = '0; bus.in_ctrl = '0;
      bus.wb_we = 1'b0;     bus.wb_rd = '0;     bus.wb_data = '0;
      bus.flush = 1'b0;     bus.out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checki("rst_out_valid", bus.out_valid, 0);
      checki("rst_in_ready", bus.in_ready, 1);
      checki("rst_stall", bus.load_use_stall, 0);
      check("rst_payload", {bus.out_instr, bus.out_op_a, bus.out_op_b, bus.out_store}, '0);
      @(posedge clk); #1;

      // Streaming: 8 back-to-back ADDI x(i+1), x2, 4i+1
      out_cycles.delete();
      wsum = 0;
      for (int i = 0; i < 8; i++) begin
         ins = (32'(4 * i + 1) << 20) | (32'd2 << 15) | (32'(i + 1) << 7) | 32'h13;
         send(ins, 32'h100 + 32'(4 * i), 32'h100 + 32'(i), 32'h200 + 32'(i), 32'(4 * i + 1),
              12'h0C0, 32'h100 + 32'(i), 32'(4 * i + 1), 32'h200 + 32'(i), w);
         wsum += w;
      end
      checki("stream_in_ready_waits", wsum, 0);
      wait_drain("stream");
      checki("stream_count", out_cycles.size(), 8);
      if (out_cycles.size() == 8) checki("stream_span", out_cycles[7] - out_cycles[0], 7);

      // Backpressure: out_ready low for 3 cycles mid-stream
      out_cycles.delete();
      fork
         begin
            int wa;
            for (int i = 0; i < 6; i++) begin
               ins = (32'(i) << 20) | (32'd1 << 15) | (32'(10 + i) << 7) | 32'h13;
               send(ins, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i), 32'hB0 + 32'(i), 32'(i),
                    12'h0C0, 32'hA0 + 32'(i), 32'(i), 32'hB0 + 32'(i), wa);
            end
         end
         begin
            repeat (3) @(posedge clk);
            #1 bus.out_ready = 1'b0;
            @(negedge clk);
            checki("bp_in_ready_c0", bus.in_ready, 1);
            @(negedge clk);
            checki("bp_in_ready_c1", bus.in_ready, 0);
            repeat (2) @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      wait_drain("bp");
      checki("bp_count", out_cycles.size(), 6);

      // Load-use: LW x5 then ADD x6,x5,x1; LW x0; ADD not using x5
      lu_case("lu_hazard", 32'h0080A283, 32'h00128333, 2, 1);
      lu_case("lu_x0", 32'h0080A003, 32'h00128333, 1, 0);
      lu_case("lu_indep", 32'h0080A283, 32'h001103B3, 1, 0);

      // Flush with both entries full and an incoming instruction
      bus.out_ready = 1'b0;
      send(32'h00100513, 32'h400, 32'h1, 32'h2, 32'h1, 12'h0C0, 32'h1, 32'h1, 32'h2, w);
      send(32'h00200593, 32'h404, 32'h3, 32'h4, 32'h2, 12'h0C0, 32'h3, 32'h2, 32'h4, w);
      drive(32'h00300613, 32'h408, 32'h5, 32'h6, 32'h3, 12'h0C0);
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      exp_q.delete();
      out_cycles.delete();
      @(negedge clk);
      checki("flush_out_valid", bus.out_valid, 0);
      checki("flush_in_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checki("flush_no_output", out_cycles.size(), 0);
      // Flush against an empty stage still drops the incoming entry
      drive(32'h00400693, 32'h40C, 32'h7, 32'h8, 32'h4, 12'h0C0);
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      checki("flush_in_out_valid", bus.out_valid, 0);
      @(posedge clk); #1;
      send(32'h00500713, 32'h410, 32'h9, 32'hA, 32'h5, 12'h0C0, 32'h9, 32'h5, 32'hA, w);
      wait_drain("flush_after");
      checki("flush_after_count", out_cycles.size(), 1);

      // Operand-A from PC and writeback bypass
      wb_exp_a = BypassOn ? 32'hDEADBEEF : 32'h0;
      bus.wb_we = 1'b1;  bus.wb_rd = 5'd3;  bus.wb_data = 32'hDEADBEEF;
      send(32'h00018213, 32'h500, 32'h0, 32'h0, 32'h0, 12'h0C0, wb_exp_a, 32'h0, 32'h0, w);
      send(32'h00318233, 32'h504, 32'h1, 32'h7, 32'h0, 12'h180,
           BypassOn ? 32'hDEADBEEF : 32'h1, BypassOn ? 32'hDEADBEEF : 32'h7,
           BypassOn ? 32'hDEADBEEF : 32'h7, w);
      bus.wb_rd = 5'd0;
      send(32'h00000213, 32'h508, 32'h55, 32'h0, 32'h0, 12'h0C0, 32'h55, 32'h0, 32'h0, w);
      bus.wb_we = 1'b0;  bus.wb_rd = 5'd3;
      send(32'h00001297, 32'h1000, 32'h99, 32'h33, 32'h1000, 12'h060,
           32'h1000, 32'h1000, 32'h33, w);
      bus.wb_rd = 5'd0;  bus.wb_data = 32'h0;
      wait_drain("bypass");

      // Reset during backpressure
      bus.out_ready = 1'b0;
      send(32'h00100793, 32'h600, 32'h1, 32'h2, 32'h1, 12'h0C0, 32'h1, 32'h1, 32'h2, w);
      send(32'h00200813, 32'h604, 32'h3, 32'h4, 32'h2, 12'h0C0, 32'h3, 32'h2, 32'h4, w);
      drive(32'h00300893, 32'h608, 32'h5, 32'h6, 32'h3, 12'h0C0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      exp_q.delete();
      out_cycles.delete();
      @(negedge clk);
      checki("mid_rst_out_valid", bus.out_valid, 0);
      checki("mid_rst_in_ready", bus.in_ready, 1);
      checki("mid_rst_stall", bus.load_use_stall, 0);
      check("mid_rst_payload", {bus.out_instr, bus.out_op_a, bus.out_op_b, bus.out_pc}, '0);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checki("mid_rst_no_output", out_cycles.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
